// File: rtl/rtc_pkg.sv
// ============================================================================
// Module   : rtc_pkg
// Brief    : Shared widths, moduli, state encoding and range check for the
//            real-time clock sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rtc_pkg;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HR_W    = 5;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOAD = 2'd2
    } state_t;

    function automatic logic time_legal(
        input logic [SEC_W-1:0] sec,
        input logic [MIN_W-1:0] min,
        input logic [HR_W-1:0]  hr
    );
        return (sec < SEC_W'(SEC_MOD)) && (min < MIN_W'(MIN_MOD)) && (hr < HR_W'(HR_MOD));
    endfunction

endpackage

`default_nettype wire

// File: rtl/mod_n_counter.sv
// ============================================================================
// Module   : mod_n_counter
// Brief    : Loadable modulo-N counter; carry flags the N-1 -> 0 wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_n_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);

    localparam logic [W-1:0] c_max = W'(N - 1);

    logic [W-1:0] r_value_q;
    logic [W-1:0] w_value_d;

    always_comb begin
        w_value_d = r_value_q;
        if (load_i) begin
            w_value_d = load_val_i;
        end else if (inc_i) begin
            w_value_d = (r_value_q == c_max) ? '0 : r_value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value_q <= '0;
        end else begin
            r_value_q <= w_value_d;
        end
    end

    assign value_o = r_value_q;
    assign carry_o = inc_i && (r_value_q == c_max);

endmodule

`default_nettype wire

// File: rtl/rtc_sequencer.sv
// ============================================================================
// Module   : rtc_sequencer
// Brief    : Prescaler, run/stop/load FSM and set-vs-tick arbitration for a
//            cascaded sec/min/hr real-time clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_sequencer
    import rtc_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_i,
    input  logic             set_valid_i,
    output logic             set_ready_o,
    input  logic [SEC_W-1:0] set_sec_i,
    input  logic [MIN_W-1:0] set_min_i,
    input  logic [HR_W-1:0]  set_hr_i,
    output logic [SEC_W-1:0] sec_o,
    output logic [MIN_W-1:0] min_o,
    output logic [HR_W-1:0]  hr_o,
    output logic             tick_o,
    output logic             rollover_o,
    output logic             err_o
);

    localparam int               c_presc_w = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(TICK_DIV - 1);

    state_t               r_state_q, w_state_d;
    logic [c_presc_w-1:0] r_presc_q, w_presc_d;
    logic [SEC_W-1:0]     r_pend_sec_q, w_pend_sec_d;
    logic [MIN_W-1:0]     r_pend_min_q, w_pend_min_d;
    logic [HR_W-1:0]      r_pend_hr_q, w_pend_hr_d;
    logic                 r_tick_q, r_roll_q, r_err_q, w_err_d;

    logic w_accept, w_wrap, w_inc, w_load, w_legal;
    logic w_sec_carry, w_min_carry, w_hr_carry;

    assign set_ready_o = (r_state_q != LOAD);
    assign w_accept    = set_valid_i && set_ready_o;
    assign w_wrap      = (r_state_q == RUN) && (r_presc_q == c_presc_last);
    // An accepted set swallows a coincident wrap: no tick, no carry.
    assign w_inc       = w_wrap && !w_accept;
    assign w_legal     = time_legal(r_pend_sec_q, r_pend_min_q, r_pend_hr_q);
    assign w_load      = (r_state_q == LOAD) && w_legal;

    always_comb begin
        w_state_d    = r_state_q;
        w_presc_d    = r_presc_q;
        w_pend_sec_d = r_pend_sec_q;
        w_pend_min_d = r_pend_min_q;
        w_pend_hr_d  = r_pend_hr_q;
        w_err_d      = 1'b0;
        if (w_accept) begin
            w_pend_sec_d = set_sec_i;
            w_pend_min_d = set_min_i;
            w_pend_hr_d  = set_hr_i;
        end
        unique case (r_state_q)
            IDLE: begin
                if (w_accept)   w_state_d = LOAD;
                else if (run_i) w_state_d = RUN;
            end
            RUN: begin
                w_presc_d = w_wrap ? '0 : r_presc_q + 1'b1;
                if (w_accept)    w_state_d = LOAD;
                else if (!run_i) w_state_d = IDLE;
            end
            LOAD: begin
                if (w_legal) w_presc_d = '0;
                else         w_err_d   = 1'b1;
                w_state_d = run_i ? RUN : IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q    <= IDLE;
            r_presc_q    <= '0;
            r_pend_sec_q <= '0;
            r_pend_min_q <= '0;
            r_pend_hr_q  <= '0;
            r_tick_q     <= 1'b0;
            r_roll_q     <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_presc_q    <= w_presc_d;
            r_pend_sec_q <= w_pend_sec_d;
            r_pend_min_q <= w_pend_min_d;
            r_pend_hr_q  <= w_pend_hr_d;
            r_tick_q     <= w_inc;
            r_roll_q     <= w_hr_carry;
            r_err_q      <= w_err_d;
        end
    end

    mod_n_counter #(.N(SEC_MOD), .W(SEC_W)) u_sec (
        .clk        (clk),
        .rst        (reset),
        .inc_i      (w_inc),
        .load_i     (w_load),
        .load_val_i (r_pend_sec_q),
        .value_o    (sec_o),
        .carry_o    (w_sec_carry)
    );

    mod_n_counter #(.N(MIN_MOD), .W(MIN_W)) u_min (
        .clk        (clk),
        .rst        (reset),
        .inc_i      (w_sec_carry),
        .load_i     (w_load),
        .load_val_i (r_pend_min_q),
        .value_o    (min_o),
        .carry_o    (w_min_carry)
    );

    mod_n_counter #(.N(HR_MOD), .W(HR_W)) u_hr (
        .clk        (clk),
        .rst        (reset),
        .inc_i      (w_min_carry),
        .load_i     (w_load),
        .load_val_i (r_pend_hr_q),
        .value_o    (hr_o),
        .carry_o    (w_hr_carry)
    );

    assign tick_o     = r_tick_q;
    assign rollover_o = r_roll_q;
    assign err_o      = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rtc_sequencer.sv
// ============================================================================
// Module   : tb_rtc_sequencer
// Brief    : Self-checking bench for rtc_sequencer with TICK_DIV = 4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_sequencer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run_i = 1'b0;
    logic       set_valid_i = 1'b0;
    logic [5:0] set_sec_i = '0;
    logic [5:0] set_min_i = '0;
    logic [4:0] set_hr_i = '0;
    logic       set_ready_o, tick_o, rollover_o, err_o;
    logic [5:0] sec_o, min_o;
    logic [4:0] hr_o;

    rtc_sequencer #(.TICK_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run_i),
        .set_valid_i (set_valid_i),
        .set_ready_o (set_ready_o),
        .set_sec_i   (set_sec_i),
        .set_min_i   (set_min_i),
        .set_hr_i    (set_hr_i),
        .sec_o       (sec_o),
        .min_o       (min_o),
        .hr_o        (hr_o),
        .tick_o      (tick_o),
        .rollover_o  (rollover_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time kept as total seconds since midnight.
    typedef struct packed {
        logic [5:0] sec;
        logic [5:0] min;
        logic [4:0] hr;
        logic       tick;
        logic       roll;
        logic       err;
        logic       ready;
    } exp_t;

    exp_t sb_q[$];
    int   m_state = 0;  // 0 stopped, 1 running, 2 loading
    int   m_presc = 0;
    int   m_total = 0;
    int   m_ps = 0, m_pm = 0, m_ph = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   acc, m_tick, m_roll, m_err;
        int   nxt;
        m_tick = 0; m_roll = 0; m_err = 0;
        if (reset) begin
            m_state = 0; m_presc = 0; m_total = 0;
            m_ps = 0; m_pm = 0; m_ph = 0;
        end else begin
            acc = set_valid_i && (m_state != 2);
            nxt = m_state;
            if (m_state == 0) begin
                nxt = acc ? 2 : (run_i ? 1 : 0);
            end else if (m_state == 1) begin
                if (m_presc == DIV - 1) begin
                    m_presc = 0;
                    if (!acc) begin
                        m_tick  = 1;
                        m_total = m_total + 1;
                        if (m_total == 86400) begin
                            m_total = 0;
                            m_roll  = 1;
                        end
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
                nxt = acc ? 2 : (run_i ? 1 : 0);
            end else begin
                if (m_ps < 60 && m_pm < 60 && m_ph < 24) begin
                    m_total = m_ph * 3600 + m_pm * 60 + m_ps;
                    m_presc = 0;
                end else begin
                    m_err = 1;
                end
                nxt = run_i ? 1 : 0;
            end
            if (acc) begin
                m_ps = int'(set_sec_i); m_pm = int'(set_min_i); m_ph = int'(set_hr_i);
            end
            m_state = nxt;
        end
        e.sec   = 6'(m_total % 60);
        e.min   = 6'((m_total / 60) % 60);
        e.hr    = 5'(m_total / 3600);
        e.tick  = m_tick;
        e.roll  = m_roll;
        e.err   = m_err;
        e.ready = (m_state != 2);
        sb_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e, a;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = {sec_o, min_o, hr_o, tick_o, rollover_o, err_o, set_ready_o};
            check("scoreboard", 32'(a), 32'(e));
        end
    end

    // Directed-sequence helpers; counters are private to the stimulus process.
    int n_tick = 0, n_roll = 0, n_err = 0;

    task automatic cyc();
        @(negedge clk);
        if (tick_o === 1'b1)     n_tick++;
        if (rollover_o === 1'b1) n_roll++;
        if (err_o === 1'b1)      n_err++;
    endtask

    task automatic wait_tick(input int budget, output int waited);
        waited = 0;
        do begin
            cyc();
            waited++;
        end while (tick_o !== 1'b1 && waited < budget);
    endtask

    task automatic do_set(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h);
        set_sec_i = s; set_min_i = m; set_hr_i = h;
        set_valid_i = 1'b1;
        cyc();
        set_valid_i = 1'b0;
    endtask

    typedef struct {
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        bit         err;
    } set_vec_t;

    set_vec_t vecs[7];

    initial begin
        int w, bad_gap, t0, r0, e0;
        logic [5:0] es, em;
        logic [4:0] eh;

        vecs[0] = '{s: 6'd58, m: 6'd59, h: 5'd23, err: 1'b0};
        vecs[1] = '{s: 6'd0,  m: 6'd60, h: 5'd12, err: 1'b1};
        vecs[2] = '{s: 6'd60, m: 6'd0,  h: 5'd0,  err: 1'b1};
        vecs[3] = '{s: 6'd0,  m: 6'd0,  h: 5'd24, err: 1'b1};
        vecs[4] = '{s: 6'd59, m: 6'd59, h: 5'd23, err: 1'b0};
        vecs[5] = '{s: 6'd7,  m: 6'd30, h: 5'd12, err: 1'b0};
        vecs[6] = '{s: 6'd63, m: 6'd63, h: 5'd31, err: 1'b1};

        // Reset held with run_i low.
        repeat (10) cyc();
        check("reset_sec", sec_o, 0);
        check("reset_min", min_o, 0);
        check("reset_hr", hr_o, 0);
        check("reset_ready", set_ready_o, 1);
        check("reset_no_tick", n_tick, 0);
        check("reset_flags", {rollover_o, err_o}, 0);

        // Free run from reset release: 60 ticks advance one minute.
        reset = 1'b0;
        run_i = 1'b1;
        t0 = n_tick;
        wait_tick(20, w);
        check("first_tick_latency", w, DIV + 1);
        bad_gap = 0;
        for (int i = 1; i < 60; i++) begin
            wait_tick(20, w);
            if (w != DIV) bad_gap++;
        end
        check("tick_spacing_errors", bad_gap, 0);
        check("tick_count_60", n_tick - t0, 60);
        check("minute_sec", sec_o, 0);
        check("minute_min", min_o, 1);
        check("minute_hr", hr_o, 0);

        // Table of set values applied while stopped.
        run_i = 1'b0;
        repeat (3) cyc();
        es = sec_o; em = min_o; eh = hr_o;
        for (int i = 0; i < 7; i++) begin
            check("ready_before_set", set_ready_o, 1);
            e0 = n_err;
            do_set(vecs[i].s, vecs[i].m, vecs[i].h);
            check("ready_low_in_load", set_ready_o, 0);
            cyc();
            if (!vecs[i].err) begin
                es = vecs[i].s; em = vecs[i].m; eh = vecs[i].h;
            end
            check("set_err", err_o, vecs[i].err);
            check("ready_back", set_ready_o, 1);
            check("set_fields", {sec_o, min_o, hr_o}, {es, em, eh});
            cyc();
            check("err_one_cycle", err_o, 0);
            check("err_count", n_err - e0, vecs[i].err);
        end

        // Rollover 23:59:58 -> 00:00:00.
        do_set(6'd58, 6'd59, 5'd23);
        cyc();
        run_i = 1'b1;
        r0 = n_roll;
        wait_tick(20, w);
        check("pre_roll_fields", {sec_o, min_o, hr_o}, {6'd59, 6'd59, 5'd23});
        wait_tick(20, w);
        check("roll_spacing", w, DIV);
        check("roll_fields", {sec_o, min_o, hr_o}, 0);
        check("roll_pulse", rollover_o, 1);
        cyc();
        check("roll_one_cycle", rollover_o, 0);
        check("roll_count", n_roll - r0, 1);

        // Set accepted in the cycle the prescaler would wrap.
        wait_tick(20, w);
        repeat (DIV - 1) cyc();
        do_set(6'd20, 6'd10, 5'd5);
        check("collide_no_tick", tick_o, 0);
        check("collide_ready_low", set_ready_o, 0);
        cyc();
        check("collide_fields", {sec_o, min_o, hr_o}, {6'd20, 6'd10, 5'd5});
        check("collide_no_tick_load", tick_o, 0);
        wait_tick(20, w);
        check("post_load_tick_gap", w, DIV);
        check("post_load_sec", sec_o, 21);

        // Pause for 7 cycles right after a tick.
        wait_tick(20, w);
        run_i = 1'b0;
        t0 = n_tick;
        repeat (7) cyc();
        check("no_tick_paused", n_tick - t0, 0);
        run_i = 1'b1;
        wait_tick(30, w);
        check("resume_gap", w + 7, DIV + 7);
        wait_tick(20, w);
        check("after_resume_gap", w, DIV);

        // Reset asserted while in LOAD.
        do_set(6'd30, 6'd20, 5'd10);
        check("pre_reset_load", set_ready_o, 0);
        reset = 1'b1;
        cyc();
        check("reset_in_load_fields", {sec_o, min_o, hr_o}, 0);
        check("reset_in_load_ready", set_ready_o, 1);
        check("reset_in_load_flags", {tick_o, rollover_o, err_o}, 0);
        reset = 1'b0;
        repeat (2) cyc();
        check("reset_drops_set", {sec_o, min_o, hr_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rtc_sequencer.md
# rtc_sequencer

Sequencing controller for a bank of cascaded mod-N counter registers that together form a real-time clock: seconds (mod 60), minutes (mod 60) and hours (mod 24). It owns the prescaler that turns the system clock into a once-per-second tick and the run/stop/load state machine. It also arbitrates between the free-running increment path and host "set time" writes through a valid/ready handshake. It sits between the host control interface and the display/readout logic of the real-time mod-N counter design.

## Interface
- TICK_DIV, 100_000_000, clk cycles per one-second tick; must be ≥ 2
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- run_i  in  1  level: 1 = count, 0 = pause
- set_valid_i  in  1  host offers a new time value
- set_ready_o  out  1  controller can accept a set request this cycle
- set_sec_i  in  6  seconds to load, legal 0..59
- set_min_i  in  6  minutes to load, legal 0..59
- set_hr_i  in  5  hours to load, legal 0..23
- sec_o  out  6  current seconds
- min_o  out  6  current minutes
- hr_o  out  5  current hours
- tick_o  out  1  one-cycle pulse, coincident with every sec_o increment
- rollover_o  out  1  one-cycle pulse when time wraps 23:59:59 → 00:00:00
- err_o  out  1  one-cycle pulse when an accepted set value is out of range

## Operation
- States: IDLE (stopped), RUN (prescaler counting), LOAD (one-cycle register write).
- Reset:
  - State is IDLE.
  - Prescaler, sec_o, min_o and hr_o are 0.
  - tick_o, rollover_o and err_o are 0.
  - set_ready_o is 1.
- IDLE → RUN when run_i = 1. RUN → IDLE when run_i = 0.
- Pause behaviour: the prescaler holds its value while paused and resumes from that value.
- Prescaler: counts 0..TICK_DIV-1 in RUN only. On TICK_DIV-1 it wraps to 0 and issues an increment.
- Increment chain:
  - sec 59 → 0 carries into min.
  - min 59 → 0 carries into hr.
  - hr 23 → 0 asserts rollover_o.
  - All three fields update in the same cycle.
- Set handshake:
  - A request is accepted when set_valid_i and set_ready_o are both 1 in the same cycle.
  - set_ready_o = 1 in IDLE and RUN, 0 in LOAD.
  - On accept, the next state is LOAD.
- LOAD:
  - If all three values are legal, they are written and the prescaler is cleared to 0.
  - If any value is out of range, nothing is written, the prescaler is untouched and err_o pulses.
  - The next state is RUN if run_i = 1, else IDLE.
- Set/tick collision: if a set is accepted in the same cycle the prescaler would wrap, the set wins. The increment is discarded: no tick_o and no carry.
- Arithmetic: every field saturates at its modulus by wrap, never by overflow. Out-of-range values never reach a field register.

## Timing
- All outputs are registered. No combinational path from any input to any output except set_ready_o, which is decoded from state.
- From reset release with run_i = 1:
  - 1 cycle to enter RUN.
  - The first tick_o arrives TICK_DIV cycles after entering RUN.
  - Subsequent ticks are spaced exactly TICK_DIV cycles apart.
- tick_o, rollover_o and the new field values appear in the same cycle.
- A set value is accepted in cycle N, written in cycle N+1 (LOAD), visible on the outputs in cycle N+2. err_o pulses in cycle N+2.
- After a legal load in RUN, the next tick_o arrives TICK_DIV cycles after the LOAD cycle.
- Reset mid-operation (any state, including LOAD): all state returns to reset values on the next edge. A pending set request is dropped.

## Structure
- Package rtc_pkg holds:
  - Widths: SEC_W = 6, MIN_W = 6, HR_W = 5.
  - Moduli: SEC_MOD = 60, MIN_MOD = 60, HR_MOD = 24.
  - State enum: IDLE, RUN, LOAD.
- Sub-module mod_n_counter, instantiated three times:
  - Parameters: N and W.
  - Inputs: inc_i, load_i, load_val_i.
  - Outputs: value_o, carry_o.
  - carry_o is high when inc_i = 1 and value_o = N-1.
- The top level contains the prescaler, the FSM, range checking and the set/tick priority logic.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset with run_i = 0 for 10 cycles → all fields 0, no tick_o, set_ready_o = 1.
- run_i = 1 from reset → tick_o every 4 cycles. After 60 ticks: sec_o = 0, min_o = 1, exactly 60 tick_o pulses.
- Set 23:59:58, then run → 2 ticks later: 00:00:00 with rollover_o high for exactly 1 cycle.
- Set 12:60:00 → err_o pulses once, fields unchanged, set_ready_o low for exactly 1 cycle.
- Set asserted in the cycle the prescaler equals 3 → loaded value appears with no increment. Next tick_o arrives 4 cycles after LOAD.
- Pause and reset:
  - Drop run_i for 7 cycles mid-count → no ticks while paused; after resume, tick spacing is preserved (prescaler held).
  - Assert reset during LOAD → all fields 0 next cycle.
